ucontrol: RTL

- Control unit for the single-cycle microcontroller datapath.
- Consumes the datapath's Opcode and zero flag. Drives the datapath's s_inc, s_inm, we3, wez and Op.
- Adds a run/pause/halt sequencer, single-step support and a retired-instruction counter, so programs can be stopped and traced on the board.
- Adds a PC write enable, pc_we, that feeds the enable-capable PC register of the next datapath revision.

---
 rtl/ucontrol.sv | 110 +++++++++++
 1 files changed

// File: rtl/ucontrol.sv
// rtl/ucontrol.sv - control unit with run/pause/halt sequencer, single step and retired-instruction counter
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode halts instead of acting as NOP).
module ucontrol #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             step_mode,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic executing;
    logic is_halt;
    logic is_illegal;
    logic trap;

    always_comb begin
        executing  = (state_q == ST_RUN) || ((state_q == ST_PAUSE) && step);
        is_halt    = (opcode == 6'b000011);
        is_illegal = !opcode[5] && (opcode[4] || opcode[3]);
        trap       = TRAP_EN && is_illegal;

        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        op    = 3'b000;
        pc_we = 1'b0;

        if (executing) begin
            pc_we = !is_halt && !trap;
            if (opcode[5]) begin
                op  = opcode[4:2];
                we3 = 1'b1;
                wez = 1'b1;
            end else if (opcode[4:2] == 3'b001) begin
                s_inm = 1'b1;
                we3   = 1'b1;
            end else if (opcode == 6'b000000) begin
                s_inc = 1'b0;
            end else if (opcode == 6'b000001) begin
                s_inc = ~z;
            end else if (opcode == 6'b000010) begin
                s_inc = z;
            end
        end

        state_d       = state_q;
        illegal_d     = illegal_q || (executing && is_illegal);
        instr_count_d = instr_count_q;

        if (executing && !is_halt && !trap)
            instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

        // HALT (or a trapped illegal opcode) beats any step_mode-driven move.
        if (executing && (is_halt || trap)) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_RUN:   if (step_mode)  state_d = ST_PAUSE;
                ST_PAUSE: if (!step_mode) state_d = ST_RUN;
                default:  state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule
